// File: rtl/bpred_pkg.sv
// Shared types and constants for the branch predictor.
// Counter encodings, allocate/reset values and the BTB entry layout.
package bpred_pkg;

   localparam int BP_XLEN  = 32;
   localparam int BP_IDX_W = 4;
   localparam int BP_TAG_W = BP_XLEN - BP_IDX_W;

   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   localparam logic [1:0] CTR_RST   = WNT;
   localparam logic [1:0] CTR_ALLOC = WT;

   typedef struct packed {
      logic                valid;
      logic [BP_TAG_W-1:0] tag;
      logic [BP_XLEN-1:0]  target;
   } btb_entry_t;

endpackage

// File: rtl/branch_predictor_sat_ctr2.sv
// 2-bit saturating counter step: dir=1 counts up, dir=0 counts down.
// Ports: ctr (current), dir (direction), ctr_next (saturated result).
module sat_ctr2
   import bpred_pkg::*;
(
   input  logic [1:0] ctr,
   input  logic       dir,
   output logic [1:0] ctr_next
);

   always_comb begin
      ctr_next = ctr;
      if (dir) begin
         if (ctr != ST) ctr_next = ctr + 2'd1;
      end else begin
         if (ctr != SNT) ctr_next = ctr - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// IF-stage branch predictor: direct-mapped 2-bit counters plus BTB,
// trained from EX resolution. Optional gshare indexing: BPRED_GSHARE_EN.
// Ports: clk, rst (sync, active-high); IF_pc -> IF_bp_taken,
// IF_bp_next_pc, IF_bp_idx; EX_brn/EX_pc/EX_bp_idx/EX_true_taken/
// EX_target train the table; EX_taken is the mispredict flag.
module branch_predictor
   import bpred_pkg::*;
#(
   parameter int XLEN  = BP_XLEN,
   parameter int IDX_W = BP_IDX_W,
   parameter int TAG_W = XLEN - IDX_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [XLEN-1:0]  IF_pc,
   output logic             IF_bp_taken,
   output logic [XLEN-1:0]  IF_bp_next_pc,
   output logic [IDX_W-1:0] IF_bp_idx,
   input  logic             EX_brn,
   input  logic [XLEN-1:0]  EX_pc,
   input  logic [IDX_W-1:0] EX_bp_idx,
   input  logic             EX_true_taken,
   input  logic [XLEN-1:0]  EX_target,
   input  logic             EX_taken
);

   localparam int DEPTH = 2**IDX_W;

   btb_entry_t       btb [DEPTH];
   logic [1:0]       ctr [DEPTH];

   logic [IDX_W-1:0] bidx;
   logic [IDX_W-1:0] cidx;
   logic [IDX_W-1:0] ubidx;
   logic             hit;
   logic             ehit;
   logic [1:0]       ctr_upd;
   logic             unused_ok;

   assign unused_ok = ^{EX_taken, EX_pc[IDX_W-1:0]};

   assign bidx = IF_pc[IDX_W-1:0];

`ifdef BPRED_GSHARE_EN
   logic [IDX_W-1:0] ghr;

   assign cidx  = bidx ^ ghr;
   // BTB stays PC-indexed; only the counters see the hashed index.
   assign ubidx = EX_pc[IDX_W-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         ghr <= '0;
      end else if (EX_brn) begin
         ghr <= {ghr[IDX_W-2:0], EX_true_taken};
      end
   end
`else
   assign cidx  = bidx;
   assign ubidx = EX_bp_idx;
`endif

   always_comb begin
      hit = btb[bidx].valid && (btb[bidx].tag == IF_pc[XLEN-1:IDX_W]);
      IF_bp_taken   = hit && ctr[cidx][1];
      IF_bp_next_pc = IF_bp_taken ? btb[bidx].target
                                  : IF_pc + XLEN'(1);
      IF_bp_idx     = cidx;
   end

   assign ehit = btb[ubidx].valid
              && (btb[ubidx].tag == EX_pc[XLEN-1:IDX_W]);

   sat_ctr2 u_sat (
      .ctr      (ctr[EX_bp_idx]),
      .dir      (EX_true_taken),
      .ctr_next (ctr_upd)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            btb[i] <= '0;
            ctr[i] <= CTR_RST;
         end
      end else if (EX_brn) begin
         if (ehit) begin
            ctr[EX_bp_idx] <= ctr_upd;
            if (EX_true_taken) btb[ubidx].target <= EX_target;
         end else if (EX_true_taken) begin
            // Miss on a taken branch evicts whatever lives here.
            btb[ubidx] <= '{valid:  1'b1,
                            tag:    EX_pc[XLEN-1:IDX_W],
                            target: EX_target};
            ctr[EX_bp_idx] <= CTR_ALLOC;
         end
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed steps, a small
// reference model and a scoreboard of expected lookup results.
module tb_branch_predictor;

   typedef struct {
      logic        taken;
      logic [31:0] next_pc;
      logic [3:0]  idx;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] IF_pc;
   logic        IF_bp_taken;
   logic [31:0] IF_bp_next_pc;
   logic [3:0]  IF_bp_idx;
   logic        EX_brn;
   logic [31:0] EX_pc;
   logic [3:0]  EX_bp_idx;
   logic        EX_true_taken;
   logic [31:0] EX_target;
   logic        EX_taken;

   int n_cmp = 0;
   int n_bad = 0;

   exp_t sb[$];

   logic        mv   [16];
   logic [27:0] mtag [16];
   logic [31:0] mtgt [16];
   logic [1:0]  mctr [16];
   logic [3:0]  mghr;

   always #5 clk = ~clk;

   branch_predictor dut (
      .clk           (clk),
      .rst           (rst),
      .IF_pc         (IF_pc),
      .IF_bp_taken   (IF_bp_taken),
      .IF_bp_next_pc (IF_bp_next_pc),
      .IF_bp_idx     (IF_bp_idx),
      .EX_brn        (EX_brn),
      .EX_pc         (EX_pc),
      .EX_bp_idx     (EX_bp_idx),
      .EX_true_taken (EX_true_taken),
      .EX_target     (EX_target),
      .EX_taken      (EX_taken)
   );

   function automatic logic [3:0] m_cidx(input logic [31:0] pc);
`ifdef BPRED_GSHARE_EN
      return pc[3:0] ^ mghr;
`else
      return pc[3:0];
`endif
   endfunction

   function automatic exp_t m_look(input logic [31:0] pc);
      exp_t e;
      logic [3:0] b;
      logic h;
      b = pc[3:0];
      h = mv[b] && (mtag[b] == pc[31:4]);
      e.idx = m_cidx(pc);
      e.taken = h && mctr[e.idx][1];
      e.next_pc = e.taken ? mtgt[b] : pc + 32'd1;
      return e;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 16; i++) begin
         mv[i] = 1'b0;
         mtag[i] = '0;
         mtgt[i] = '0;
         mctr[i] = 2'b01;
      end
      mghr = '0;
   endtask

   task automatic m_update(input logic [31:0] pc, input logic [3:0] ci,
                           input logic t, input logic [31:0] tgt);
      logic [3:0] b;
      logic h;
`ifdef BPRED_GSHARE_EN
      b = pc[3:0];
`else
      b = ci;
`endif
      h = mv[b] && (mtag[b] == pc[31:4]);
      if (h) begin
         if (t) begin
            if (mctr[ci] != 2'b11) mctr[ci] = mctr[ci] + 2'd1;
            mtgt[b] = tgt;
         end else if (mctr[ci] != 2'b00) begin
            mctr[ci] = mctr[ci] - 2'd1;
         end
      end else if (t) begin
         mv[b] = 1'b1;
         mtag[b] = pc[31:4];
         mtgt[b] = tgt;
         mctr[ci] = 2'b10;
      end
      mghr = {mghr[2:0], t};
   endtask

   task automatic look(input logic [31:0] pc, input string tag);
      exp_t e;
      IF_pc = pc;
      sb.push_back(m_look(pc));
      #1;
      e = sb.pop_front();
      n_cmp++;
      assert (IF_bp_taken === e.taken) else begin
         n_bad++;
         $error("FAIL %s taken: got %0h want %0h",
                tag, IF_bp_taken, e.taken);
      end
      n_cmp++;
      assert (IF_bp_next_pc === e.next_pc) else begin
         n_bad++;
         $error("FAIL %s next_pc: got %0h want %0h",
                tag, IF_bp_next_pc, e.next_pc);
      end
      n_cmp++;
      assert (IF_bp_idx === e.idx) else begin
         n_bad++;
         $error("FAIL %s idx: got %0h want %0h",
                tag, IF_bp_idx, e.idx);
      end
   endtask

   task automatic upd(input logic [31:0] pc, input logic t,
                      input logic [31:0] tgt);
      logic [3:0] ci;
      ci = m_cidx(pc);
      EX_brn = 1'b1;
      EX_pc = pc;
      EX_bp_idx = ci;
      EX_true_taken = t;
      EX_target = tgt;
      EX_taken = 1'($urandom);
      @(posedge clk);
      m_update(pc, ci, t, tgt);
      #1;
      EX_brn = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      m_reset();
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      IF_pc = 32'd5;
      EX_brn = 1'b0;
      EX_pc = '0;
      EX_bp_idx = '0;
      EX_true_taken = 1'b0;
      EX_target = '0;
      EX_taken = 1'b0;

      // Reset held: outputs already default after first edge.
      @(posedge clk);
      m_reset();
      #1;
      look(32'd5, "rst_hold");
      @(posedge clk);
      #1;
      rst = 1'b0;
      look(32'd5, "reset");
      n_cmp++;
      assert (IF_bp_next_pc === 32'd6) else begin
         n_bad++;
         $error("FAIL reset_const: got %0h want 6", IF_bp_next_pc);
      end

      // Allocate then decay.
      upd(32'd5, 1'b1, 32'd20);
      look(32'd5, "alloc");
      upd(32'd5, 1'b0, 32'd6);
      look(32'd5, "nt1");
      upd(32'd5, 1'b0, 32'd6);
      look(32'd5, "nt2");

      // Saturation.
      for (int i = 0; i < 5; i++) upd(32'd5, 1'b1, 32'd20);
      look(32'd5, "sat_hi");
      upd(32'd5, 1'b0, 32'd6);
      look(32'd5, "sat_nt1");
      upd(32'd5, 1'b0, 32'd6);
      look(32'd5, "sat_nt2");

      // Alias at pc+DEPTH.
      upd(32'd5, 1'b1, 32'd20);
      look(32'd5, "alias_pre");
      look(32'd21, "alias_miss");
      upd(32'd21, 1'b1, 32'd30);
      look(32'd21, "alias_own");
      look(32'd5, "alias_evict");

      // Same-cycle lookup sees old contents.
      do_reset();
      EX_brn = 1'b1;
      EX_pc = 32'd5;
      EX_bp_idx = m_cidx(32'd5);
      EX_true_taken = 1'b1;
      EX_target = 32'd40;
      look(32'd5, "same_cyc");
      @(posedge clk);
      m_update(32'd5, m_cidx(32'd5), 1'b1, 32'd40);
      #1;
      EX_brn = 1'b0;
      look(32'd5, "after_cyc");

      // Reset beats a concurrent update.
      rst = 1'b1;
      EX_brn = 1'b1;
      EX_pc = 32'd9;
      EX_bp_idx = 4'd9;
      EX_true_taken = 1'b1;
      EX_target = 32'd77;
      @(posedge clk);
      m_reset();
      #1;
      rst = 1'b0;
      EX_brn = 1'b0;
      look(32'd9, "rst_drop");
      look(32'd5, "rst_clear");

      // Mixed traffic over a few aliasing PCs.
      for (int i = 0; i < 40; i++) begin
         logic [31:0] p;
         p = 32'($urandom_range(0, 7)) + 32'($urandom_range(0, 1)) * 32'd16;
         upd(p, 1'($urandom), 32'($urandom_range(100, 200)));
         look(32'($urandom_range(0, 7)) + 32'd16 * 32'($urandom_range(0, 1)),
              "rand");
      end

`ifdef BPRED_GSHARE_EN
      do_reset();
      look(32'd3, "ghr_rst");
      upd(32'd1, 1'b0, 32'd2);
      upd(32'd2, 1'b1, 32'd50);
      upd(32'd7, 1'b0, 32'd8);
      upd(32'd8, 1'b1, 32'd60);
      look(32'd3, "ghr_0101");
      n_cmp++;
      assert (IF_bp_idx === 4'd6) else begin
         n_bad++;
         $error("FAIL ghr_idx: got %0h want 6", IF_bp_idx);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- IF-stage predictor that supplies the predicted taken bit and next PC for every fetch; the taken bit travels down the pipeline to EX.
- Direct-mapped table per entry: 2-bit saturating counter plus BTB (valid, tag, target).
- Trained non-speculatively from EX branch resolution: resolved direction, correct target, mispredict flag.
- PCs are word addresses; fall-through is PC+1.

Parameters:
- XLEN, 32, PC/target width.
- IDX_W, 4, index bits; DEPTH = 2**IDX_W entries.
- TAG_W, XLEN-IDX_W, tag width; tag = pc[XLEN-1:IDX_W].

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- IF_pc  in  XLEN  fetch PC.
- IF_bp_taken  out  1  predicted taken.
- IF_bp_next_pc  out  XLEN  predicted next PC.
- IF_bp_idx  out  IDX_W  table index used; carried down the pipeline to EX.
- EX_brn  in  1  branch/jump resolving in EX this cycle; update strobe.
- EX_pc  in  XLEN  PC of the resolving branch.
- EX_bp_idx  in  IDX_W  index carried from IF for that branch.
- EX_true_taken  in  1  resolved direction.
- EX_target  in  XLEN  resolved next PC; equals the branch target when EX_true_taken=1.
- EX_taken  in  1  mispredict/flush flag; drives the optional statistic only.

Behaviour:
- Lookup, combinational, zero latency:
  - idx = IF_pc[IDX_W-1:0].
  - hit = valid[idx] && tag[idx]==IF_pc tag.
  - IF_bp_taken = hit && ctr[idx][1].
  - IF_bp_next_pc = IF_bp_taken ? tgt[idx] : IF_pc+1, modulo 2^XLEN.
  - IF_bp_idx = idx.
- Update at posedge when EX_brn=1 and rst=0; index = EX_bp_idx; ehit = valid && tag match against EX_pc:
  - ehit, taken: ctr = min(ctr+1, 3); tgt = EX_target.
  - ehit, not taken: ctr = max(ctr-1, 0); tgt unchanged.
  - miss, taken: allocate (replace any occupant): valid=1, tag=EX_pc tag, tgt=EX_target, ctr=2'b10.
  - miss, not taken: no state change.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; saturates at both ends, no wrap.
- Update is visible from the cycle after the edge. A same-cycle lookup of the entry being written returns the old contents; there is no bypass.
- Only one update per cycle. EX_brn=0 leaves all state unchanged.
- Reset (synchronous, has priority over update):
  - all valid=0, all ctr=01, tags/targets 0, history 0.
  - Outputs are combinational, so during and after reset: IF_bp_taken=0, IF_bp_next_pc=IF_pc+1.
- rst asserted in a cycle with EX_brn=1: the update is dropped.
- Jumps resolve with EX_true_taken=1 and train like any other taken branch.

Optional Feature:
- Macro: BPRED_GSHARE_EN.
- Defined:
  - IDX_W-bit global history register ghr.
  - Counter index = IF_pc[IDX_W-1:0] ^ ghr; IF_bp_idx outputs this value.
  - On each update, ghr <= {ghr[IDX_W-2:0], EX_true_taken}.
  - BTB valid/tag/target stay indexed by PC bits and are written at EX_pc[IDX_W-1:0].
  - Update of the counter uses EX_bp_idx.
- Undefined: no ghr; counter index equals the BTB index (the base behaviour above).

Decomposition:
- Package bpred_pkg:
  - counter localparams (SNT, WNT, WT, ST) and reset value WNT.
  - allocate value WT.
  - BTB entry struct/typedef {valid, tag, target}.
- One natural sub-module: sat_ctr2, the pure saturating inc/dec function/module (inputs ctr, dir; output next ctr). It is reused per entry on the update path.

Test Plan:
- Reset, then IF_pc=5 -> IF_bp_taken=0, IF_bp_next_pc=6, IF_bp_idx=5.
- Update EX_pc=5, taken, EX_target=20 -> next cycle IF_pc=5 gives taken=1, next_pc=20. Then two not-taken updates (10->01->00) -> taken=0, next_pc=6.
- Saturation: five taken updates on pc=5, then one not-taken -> ctr=10, still taken. A second not-taken -> not taken.
- Alias: entry for pc=5 trained taken; IF_pc=5+DEPTH (21) -> taken=0, next_pc=22 (tag miss). Taken update on 21 replaces the entry, so pc=5 now misses.
- Same cycle: IF_pc=5 while a taken allocate on pc=5 commits -> that cycle taken=0; following cycle taken=1. rst asserted with EX_brn=1 -> no allocation.
- With BPRED_GSHARE_EN: after ghr=0101, IF_pc=3 -> IF_bp_idx=6. Updates shift ghr; ghr reads 0 after reset.
